// File: rtl/mem_pkg.sv
// Purpose: command encodings, FSM state type and a decode helper for the memory port arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package mem_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t MNONE  = 2'b00;
  localparam cmd_t MREAD  = 2'b01;
  localparam cmd_t MWRITE = 2'b10;
  localparam cmd_t MILL   = 2'b11;  // illegal; behaves as MNONE but flags err

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  // A requester only competes for the RAM with a read or a write.
  function automatic logic cmd_active(input cmd_t c);
    return (c == MREAD) || (c == MWRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles both requester ports and the RAM port of the memory port arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold cmd until ack; the arbiter never drops a request.
// Modports: slave = arbiter side, master = requester/RAM side.
interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 16
);

  cmd_t          req0_cmd;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ack;
  logic [DW-1:0] req0_rdata;

  cmd_t          req1_cmd;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ack;
  logic [DW-1:0] req1_rdata;

  cmd_t          ram_cmd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  req0_cmd, req0_addr, req0_wdata,
    output req0_ack, req0_rdata,
    input  req1_cmd, req1_addr, req1_wdata,
    output req1_ack, req1_rdata,
    output ram_cmd, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_cmd, req0_addr, req0_wdata,
    input  req0_ack, req0_rdata,
    output req1_cmd, req1_addr, req1_wdata,
    input  req1_ack, req1_rdata,
    input  ram_cmd, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Purpose: two-way picker with a last_grant register; fixed_pri forces requester 0 on ties.
// Latency: combinational pick; last_grant updates on the clock edge of each grant.
// Backpressure: grant_en gates the history update so only real grants move the pointer.
// Ports: clk/rst_n, fixed_pri, req[1:0], grant_en in; gnt_id, any out.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fixed_pri,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_id,
  output logic       any
);

  logic last_q;

  always_comb begin
    any    = |req;
    gnt_id = 1'b0;
    case (req)
      2'b10:   gnt_id = 1'b1;
      // Tie: round-robin hands it to whoever was not served last.
      2'b11:   gnt_id = fixed_pri ? 1'b0 : ~last_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (grant_en && any) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port synchronous RAM between two masters (IDLE -> ACCESS x RAM_LAT -> DONE).
// Latency: request seen in IDLE cycle T is acked in cycle T+RAM_LAT+1; one transaction per RAM_LAT+2 cycles.
// Backpressure: the loser and any request arriving while busy simply wait with cmd held; nothing is dropped.
// Ports: clk, reset (async, active-low), bus (requesters + RAM, slave modport), busy, grant_id, err.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int RAM_LAT   = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                grant_id,
  output logic                err
);

  localparam logic [2:0] LAST = 3'(RAM_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q;
  cmd_t          cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          gid_q;
  logic          err_q;

  logic          pick;
  logic          any_req;
  logic [DW-1:0] done_rdata;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .fixed_pri (FIXED_PRI != 0),
    .req       ({cmd_active(bus.req1_cmd), cmd_active(bus.req0_cmd)}),
    .grant_en  (state_q == IDLE),
    .gnt_id    (pick),
    .any       (any_req)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      gid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // The winner's command is captured here so later input changes cannot disturb the access.
      if (state_q == IDLE && any_req) begin
        gid_q   <= pick;
        cnt_q   <= '0;
        cmd_q   <= pick ? bus.req1_cmd   : bus.req0_cmd;
        addr_q  <= pick ? bus.req1_addr  : bus.req0_addr;
        wdata_q <= pick ? bus.req1_wdata : bus.req0_wdata;
      end else if (state_q == ACCESS && cnt_q != LAST) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (state_q == IDLE && (bus.req0_cmd == MILL || bus.req1_cmd == MILL)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Writes return zero data; reads return whatever the RAM delivered for the last ACCESS cycle.
  assign done_rdata = (cmd_q == MREAD) ? bus.ram_rdata : '0;

  always_comb begin
    bus.ram_cmd    = MNONE;
    bus.req0_ack   = 1'b0;
    bus.req1_ack   = 1'b0;
    bus.req0_rdata = '0;
    bus.req1_rdata = '0;
    if (state_q == ACCESS) begin
      bus.ram_cmd = cmd_q;
    end
    if (state_q == DONE) begin
      if (gid_q) begin
        bus.req1_ack   = 1'b1;
        bus.req1_rdata = done_rdata;
      end else begin
        bus.req0_ack   = 1'b1;
        bus.req0_rdata = done_rdata;
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = gid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with three instances (RR lat1, fixed-pri lat1, RR lat3).
// Latency: checks ack timing against T+RAM_LAT+1 and the RAM_LAT+2 back-to-back period.
// Backpressure: requesters hold cmd under contention; expected acks come from a scoreboard queue.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  cmd_t        r0_cmd, r1_cmd;
  logic [8:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        busy_a, busy_b, busy_c;
  logic        gid_a, gid_b, gid_c;
  logic        err_a, err_b, err_c;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        sb_b[$];

  mem_port_arbiter_if #(.AW(9), .DW(16)) bus_a ();
  mem_port_arbiter_if #(.AW(9), .DW(16)) bus_b ();
  mem_port_arbiter_if #(.AW(9), .DW(16)) bus_c ();

  mem_port_arbiter #(.AW(9), .DW(16), .RAM_LAT(1), .FIXED_PRI(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .grant_id(gid_a), .err(err_a));
  mem_port_arbiter #(.AW(9), .DW(16), .RAM_LAT(1), .FIXED_PRI(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .grant_id(gid_b), .err(err_b));
  mem_port_arbiter #(.AW(9), .DW(16), .RAM_LAT(3), .FIXED_PRI(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c), .busy(busy_c), .grant_id(gid_c), .err(err_c));

  // All three instances see the same requester stimulus.
  assign bus_a.req0_cmd = r0_cmd; assign bus_a.req0_addr = r0_addr; assign bus_a.req0_wdata = r0_wdata;
  assign bus_a.req1_cmd = r1_cmd; assign bus_a.req1_addr = r1_addr; assign bus_a.req1_wdata = r1_wdata;
  assign bus_b.req0_cmd = r0_cmd; assign bus_b.req0_addr = r0_addr; assign bus_b.req0_wdata = r0_wdata;
  assign bus_b.req1_cmd = r1_cmd; assign bus_b.req1_addr = r1_addr; assign bus_b.req1_wdata = r1_wdata;
  assign bus_c.req0_cmd = r0_cmd; assign bus_c.req0_addr = r0_addr; assign bus_c.req0_wdata = r0_wdata;
  assign bus_c.req1_cmd = r1_cmd; assign bus_c.req1_addr = r1_addr; assign bus_c.req1_wdata = r1_wdata;

  // Synchronous RAM models: read data appears one cycle after a read command.
  logic [15:0] mem_a [512];
  logic [15:0] mem_b [512];
  logic [15:0] mem_c [512];

  always @(posedge clk) begin
    if (!reset) begin
      mem_a[5] <= 16'h1234; mem_a[6] <= 16'h6666; mem_a[7] <= 16'h5A5A; bus_a.ram_rdata <= '0;
    end else begin
      if (bus_a.ram_cmd == MWRITE) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
      if (bus_a.ram_cmd == MREAD) bus_a.ram_rdata <= mem_a[bus_a.ram_addr];
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      mem_b[5] <= 16'h1234; mem_b[6] <= 16'h6666; mem_b[7] <= 16'h5A5A; bus_b.ram_rdata <= '0;
    end else begin
      if (bus_b.ram_cmd == MWRITE) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
      if (bus_b.ram_cmd == MREAD) bus_b.ram_rdata <= mem_b[bus_b.ram_addr];
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      mem_c[5] <= 16'h1234; mem_c[6] <= 16'h6666; mem_c[7] <= 16'h5A5A; bus_c.ram_rdata <= '0;
    end else begin
      if (bus_c.ram_cmd == MWRITE) mem_c[bus_c.ram_addr] <= bus_c.ram_wdata;
      if (bus_c.ram_cmd == MREAD) bus_c.ram_rdata <= mem_c[bus_c.ram_addr];
    end
  end

  logic [2:0]  ack0_v, ack1_v;
  logic [15:0] rd0_v [3];
  logic [15:0] rd1_v [3];

  always_comb begin
    ack0_v   = {bus_c.req0_ack, bus_b.req0_ack, bus_a.req0_ack};
    ack1_v   = {bus_c.req1_ack, bus_b.req1_ack, bus_a.req1_ack};
    rd0_v[0] = bus_a.req0_rdata; rd0_v[1] = bus_b.req0_rdata; rd0_v[2] = bus_c.req0_rdata;
    rd1_v[0] = bus_a.req1_rdata; rd1_v[1] = bus_b.req1_rdata; rd1_v[2] = bus_c.req1_rdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    r0_cmd = MNONE; r0_addr = '0; r0_wdata = '0;
    r1_cmd = MNONE; r1_addr = '0; r1_wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    sb_b.delete();
  endtask

  // Drive one request for a single IDLE cycle, then withdraw it once it has been latched.
  task automatic do_txn(input bit port, input cmd_t cmd, input logic [8:0] addr, input logic [15:0] wd);
    @(posedge clk); #1;
    if (port) begin r1_cmd = cmd; r1_addr = addr; r1_wdata = wd; end
    else      begin r0_cmd = cmd; r0_addr = addr; r0_wdata = wd; end
    @(posedge clk); #1;
    r0_cmd = MNONE;
    r1_cmd = MNONE;
  endtask

  // Observe (not judge) the first ack on one instance within a cycle budget.
  task automatic wait_ack(input int inst, input int budget, output bit got, output int k,
                          output logic id, output logic [15:0] data);
    got = 1'b0; k = 0; id = 1'b0; data = '0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      k = k + 1;
      if (ack0_v[inst] || ack1_v[inst]) begin
        got  = 1'b1;
        id   = ack1_v[inst];
        data = ack1_v[inst] ? rd1_v[inst] : rd0_v[inst];
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1 r1_cmd = MREAD; r1_addr = 9'd5; r1_wdata = 16'hAAAA;
    @(posedge clk); #1 r1_cmd = MNONE;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %0b required 1", busy_a); end
    n_checks++; if (gid_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gid: got %0b required 1", gid_a); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus_a.req0_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack0: got %0b required 0", bus_a.req0_ack); end
    n_checks++; if (bus_a.req1_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack1: got %0b required 0", bus_a.req1_ack); end
    n_checks++; if (bus_a.req0_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata0: got %h required 0000", bus_a.req0_rdata); end
    n_checks++; if (bus_a.req1_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata1: got %h required 0000", bus_a.req1_rdata); end
    n_checks++; if (bus_a.ram_cmd !== MNONE) begin n_fail++; $display("FAIL rst_ram_cmd: got %0d required 0", bus_a.ram_cmd); end
    n_checks++; if (bus_a.ram_addr !== 9'h0) begin n_fail++; $display("FAIL rst_ram_addr: got %h required 000", bus_a.ram_addr); end
    n_checks++; if (bus_a.ram_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_ram_wdata: got %h required 0000", bus_a.ram_wdata); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy_a); end
    n_checks++; if (gid_a !== 1'b0) begin n_fail++; $display("FAIL rst_gid: got %0b required 0", gid_a); end
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b required 0", err_a); end
    n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL rst_busy_c: got %0b required 0", busy_c); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_single_read();
    exp_t e;
    apply_reset();
    e.id = 1'b0; e.data = 16'h1234; sb.push_back(e);
    @(posedge clk); #1 r0_cmd = MREAD; r0_addr = 9'd5;
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rd_idle_busy: got %0b required 0", busy_a); end
    @(posedge clk); #1 r0_cmd = MNONE;
    @(negedge clk);
    n_checks++; if (bus_a.ram_cmd !== MREAD) begin n_fail++; $display("FAIL rd_ram_cmd: got %0d required 1", bus_a.ram_cmd); end
    n_checks++; if (bus_a.ram_addr !== 9'd5) begin n_fail++; $display("FAIL rd_ram_addr: got %h required 005", bus_a.ram_addr); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rd_access_busy: got %0b required 1", busy_a); end
    @(negedge clk);
    n_checks++; if (bus_a.req0_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack0: got %0b required 1", bus_a.req0_ack); end
    n_checks++; if (bus_a.req1_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack1: got %0b required 0", bus_a.req1_ack); end
    n_checks++; if (bus_a.ram_cmd !== MNONE) begin n_fail++; $display("FAIL rd_done_cmd: got %0d required 0", bus_a.ram_cmd); end
    n_checks++; if (bus_a.ram_addr !== 9'd5) begin n_fail++; $display("FAIL rd_done_addr: got %h required 005", bus_a.ram_addr); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus_a.req0_rdata !== e.data) begin n_fail++; $display("FAIL rd_rdata: got %h required %h", bus_a.req0_rdata, e.data); end
    end
    @(negedge clk);
    n_checks++; if (bus_a.req0_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %0b required 0", bus_a.req0_ack); end
  endtask

  task automatic test_write_read();
    exp_t e; bit got; int k; logic id; logic [15:0] data;
    apply_reset();
    e.id = 1'b1; e.data = 16'h0000; sb.push_back(e);
    do_txn(1'b1, MWRITE, 9'h1FF, 16'hBEEF);
    wait_ack(0, 10, got, k, id, data);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL wr_ack: got none required ack"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (k != 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", k); end
      n_checks++; if (id !== e.id) begin n_fail++; $display("FAIL wr_id: got %0b required %0b", id, e.id); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL wr_rdata: got %h required %h", data, e.data); end
    end
    e.id = 1'b1; e.data = 16'hBEEF; sb.push_back(e);
    do_txn(1'b1, MREAD, 9'h1FF, 16'h0000);
    wait_ack(0, 10, got, k, id, data);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL wrrd_ack: got none required ack"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (id !== e.id) begin n_fail++; $display("FAIL wrrd_id: got %0b required %0b", id, e.id); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL wrrd_rdata: got %h required %h", data, e.data); end
    end
  endtask

  task automatic test_contention();
    exp_t e; int na; int nb; int k; int last_a; logic ida;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      e.id = (i % 2 == 1); e.data = (i % 2 == 1) ? 16'h5A5A : 16'h1234; sb.push_back(e);
      e.id = 1'b0; e.data = 16'h1234; sb_b.push_back(e);
    end
    na = 0; nb = 0; k = 0; last_a = 0;
    @(posedge clk); #1;
    r0_cmd = MREAD; r0_addr = 9'd5; r1_cmd = MREAD; r1_addr = 9'd7;
    for (int cyc = 0; cyc < 40 && (na < 6 || nb < 6); cyc++) begin
      @(negedge clk);
      k = k + 1;
      if (bus_a.req0_ack || bus_a.req1_ack) begin
        n_checks++; if (bus_a.req0_ack && bus_a.req1_ack) begin n_fail++; $display("FAIL rr_double_ack: got 2 acks required 1"); end
        ida = bus_a.req1_ack;
        n_checks++; if (k - last_a != ((na == 0) ? 3 : 3)) begin n_fail++; $display("FAIL rr_spacing: got %0d required 3", k - last_a); end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rr_extra_ack: got ack %0d required none", na); end
        else begin
          e = sb.pop_front();
          n_checks++; if (ida !== e.id) begin n_fail++; $display("FAIL rr_grant_%0d: got %0b required %0b", na, ida, e.id); end
          n_checks++; if ((ida ? bus_a.req1_rdata : bus_a.req0_rdata) !== e.data) begin
            n_fail++; $display("FAIL rr_rdata_%0d: got %h required %h", na, ida ? bus_a.req1_rdata : bus_a.req0_rdata, e.data); end
        end
        last_a = k;
        na++;
      end
      if (bus_b.req0_ack || bus_b.req1_ack) begin
        n_checks++;
        if (sb_b.size() == 0) begin n_fail++; $display("FAIL fp_extra_ack: got ack %0d required none", nb); end
        else begin
          e = sb_b.pop_front();
          n_checks++; if (bus_b.req1_ack !== e.id) begin n_fail++; $display("FAIL fp_grant_%0d: got %0b required %0b", nb, bus_b.req1_ack, e.id); end
          n_checks++; if (bus_b.req0_rdata !== e.data) begin n_fail++; $display("FAIL fp_rdata_%0d: got %h required %h", nb, bus_b.req0_rdata, e.data); end
        end
        nb++;
      end
    end
    r0_cmd = MNONE; r1_cmd = MNONE;
    n_checks++; if (na != 6) begin n_fail++; $display("FAIL rr_ack_count: got %0d required 6", na); end
    n_checks++; if (nb != 6) begin n_fail++; $display("FAIL fp_ack_count: got %0d required 6", nb); end
  endtask

  task automatic test_input_change();
    exp_t e; bit got; int k; logic id; logic [15:0] data;
    apply_reset();
    e.id = 1'b0; e.data = 16'h1234; sb.push_back(e);
    @(posedge clk); #1 r0_cmd = MREAD; r0_addr = 9'd5;
    @(posedge clk); #1 r0_cmd = MNONE; r0_addr = 9'd6;
    @(negedge clk);
    n_checks++; if (bus_a.ram_addr !== 9'd5) begin n_fail++; $display("FAIL chg_ram_addr: got %h required 005", bus_a.ram_addr); end
    n_checks++; if (bus_a.ram_cmd !== MREAD) begin n_fail++; $display("FAIL chg_ram_cmd: got %0d required 1", bus_a.ram_cmd); end
    wait_ack(0, 10, got, k, id, data);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL chg_ack: got none required ack"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (k != 1) begin n_fail++; $display("FAIL chg_latency: got %0d required 1", k); end
      n_checks++; if (id !== e.id) begin n_fail++; $display("FAIL chg_id: got %0b required %0b", id, e.id); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL chg_rdata: got %h required %h", data, e.data); end
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e; bit got; int k; int stray; logic id; logic [15:0] data;
    apply_reset();
    @(posedge clk); #1 r0_cmd = MREAD; r0_addr = 9'd5;
    @(posedge clk); #1 r0_cmd = MNONE;
    @(negedge clk);
    n_checks++; if (bus_c.ram_cmd !== MREAD) begin n_fail++; $display("FAIL mid_access_cmd: got %0d required 1", bus_c.ram_cmd); end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    n_checks++; if (bus_c.ram_cmd !== MNONE) begin n_fail++; $display("FAIL mid_rst_cmd: got %0d required 0", bus_c.ram_cmd); end
    n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b required 0", busy_c); end
    n_checks++; if (bus_c.ram_addr !== 9'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h required 000", bus_c.ram_addr); end
    stray = 0;
    if (ack0_v[2] || ack1_v[2]) stray++;
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack0_v[2] || ack1_v[2]) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks required 0", stray); end
    e.id = 1'b0; e.data = 16'h1234; sb.push_back(e);
    do_txn(1'b0, MREAD, 9'd5, 16'h0000);
    wait_ack(2, 10, got, k, id, data);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL mid_after_ack: got none required ack"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (k != 4) begin n_fail++; $display("FAIL mid_after_latency: got %0d required 4", k); end
      n_checks++; if (id !== e.id) begin n_fail++; $display("FAIL mid_after_id: got %0b required %0b", id, e.id); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL mid_after_rdata: got %h required %h", data, e.data); end
    end
  endtask

  task automatic test_illegal_cmd();
    exp_t e; bit got; int k; logic id; logic [15:0] data;
    apply_reset();
    @(posedge clk); #1 r0_cmd = MILL; r0_addr = 9'd5;
    @(negedge clk);
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ill_err_early: got %0b required 0", err_a); end
    @(posedge clk); #1 r0_cmd = MNONE;
    @(negedge clk);
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %0b required 1", err_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ill_no_grant: got %0b required 0", busy_a); end
    e.id = 1'b1; e.data = 16'h5A5A; sb.push_back(e);
    do_txn(1'b1, MREAD, 9'd7, 16'h0000);
    wait_ack(0, 10, got, k, id, data);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL ill_legal_ack: got none required ack"); end
    else begin
      e = sb.pop_front();
      n_checks++; if (id !== e.id) begin n_fail++; $display("FAIL ill_legal_id: got %0b required %0b", id, e.id); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL ill_legal_rdata: got %h required %h", data, e.data); end
    end
    n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky: got %0b required 1", err_a); end
    apply_reset();
    n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ill_err_cleared: got %0b required 0", err_a); end
  endtask

  initial begin
    reset = 1'b0;
    r0_cmd = MNONE; r0_addr = '0; r0_wdata = '0;
    r1_cmd = MNONE; r1_addr = '0; r1_wdata = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_input_change();
    test_reset_mid_access();
    test_illegal_cmd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
